// File: rtl/core_pkg.sv
// Shared definitions for the 19-bit pipelined MIPS core: instruction field
// positions, instruction classes and the fetch-stage state type.
package core_pkg;

    localparam int INSTR_W  = 19;
    localparam int OPC_HI   = 18;
    localparam int OPC_LO   = 14;
    localparam int CLASS_HI = 18;
    localparam int CLASS_LO = 16;

    localparam logic [2:0]         CLASS_JUMP   = 3'b111;
    localparam logic [2:0]         CLASS_BRANCH = 3'b101;
    localparam logic [INSTR_W-1:0] NOP_INSTR    = 19'b0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fetch_state_e;

    function automatic logic is_jump(input logic [2:0] cls);
        return cls == CLASS_JUMP;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidates for the fetch stage: sequential PC+1 and the
// redirect target (absolute jump or PC-relative branch from the IF/ID contents).
module pc_next_calc
    import core_pkg::*;
#(
    parameter int PC_W     = 12,
    parameter int BR_OFF_W = 8
) (
    input  logic [PC_W-1:0]     i_pc,
    input  logic [2:0]          i_ifid_class,
    input  logic [PC_W-1:0]     i_ifid_jump_field,
    input  logic [BR_OFF_W-1:0] i_ifid_br_off,
    input  logic [PC_W-1:0]     i_ifid_pc_plus1,
    output logic [PC_W-1:0]     o_pc_plus1,
    output logic [PC_W-1:0]     o_target
);

    logic [PC_W-1:0] w_br_off_sext;
    logic [PC_W-1:0] w_br_target;

    // Branch arithmetic wraps modulo 2^PC_W; there is deliberately no saturation.
    assign w_br_off_sext = {{(PC_W-BR_OFF_W){i_ifid_br_off[BR_OFF_W-1]}}, i_ifid_br_off};
    assign w_br_target   = i_ifid_pc_plus1 + w_br_off_sext;
    assign o_pc_plus1    = i_pc + PC_W'(1);
    assign o_target      = is_jump(i_ifid_class) ? i_ifid_jump_field : w_br_target;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register: owns the PC, drives
// the instruction-memory address and applies hazard-unit stalls and flushes.
module fetch_stage
    import core_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              BR_OFF_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_writebar,
    input  logic               IF_ID_loadbar,
    input  logic               IF_ID_flush,
    input  logic               do_branch,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] IF_ID_instruction,
    output logic [PC_W-1:0]    IF_ID_pc_plus1,
    output logic               IF_ID_valid
);

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_plus1;
    logic               r_valid;
    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [PC_W-1:0]    w_pc_plus1;
    logic [PC_W-1:0]    w_target;

    pc_next_calc #(
        .PC_W     (PC_W),
        .BR_OFF_W (BR_OFF_W)
    ) u_pc_next_calc (
        .i_pc              (r_pc),
        .i_ifid_class      (r_instr[CLASS_HI:CLASS_LO]),
        .i_ifid_jump_field (r_instr[PC_W-1:0]),
        .i_ifid_br_off     (r_instr[BR_OFF_W-1:0]),
        .i_ifid_pc_plus1   (r_pc_plus1),
        .o_pc_plus1        (w_pc_plus1),
        .o_target          (w_target)
    );

    // Flush outranks both holds; otherwise PC and IF/ID are held independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (IF_ID_flush) begin
            r_pc       <= w_target;
            r_instr    <= NOP_INSTR;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (!pc_writebar) begin
                r_pc <= w_pc_plus1;
            end
            if (!IF_ID_loadbar) begin
                r_instr    <= imem_data;
                r_pc_plus1 <= w_pc_plus1;
                r_valid    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = RUN;
        if (pc_writebar && !IF_ID_flush) begin
            w_state_next = STALL;
        end
    end

    assign imem_addr         = r_pc;
    assign IF_ID_instruction = r_instr;
    assign IF_ID_pc_plus1    = r_pc_plus1;
    assign IF_ID_valid       = r_valid;

`ifndef SYNTHESIS
    // The stall state is only observable here: a held PC must not move.
    a_enter_stall: assert property (@(posedge clk) disable iff (reset)
        (pc_writebar && !IF_ID_flush) |=> (r_state == STALL));
    a_stall_pc_stable: assert property (@(posedge clk) disable iff (reset)
        (r_state == STALL && pc_writebar && !IF_ID_flush) |=> $stable(r_pc));
    a_flush_branch_known: assert property (@(posedge clk) disable iff (reset)
        IF_ID_flush |-> !$isunknown(do_branch));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized plus directed testbench for fetch_stage: a reference model pushes
// expected post-edge state into a scoreboard that a monitor drains every cycle.
module tb_fetch_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pcWritebar = 1'b0;
    logic        ifIdLoadbar = 1'b0;
    logic        ifIdFlush = 1'b0;
    logic        doBranch = 1'b0;
    logic [11:0] imemAddr;
    logic [18:0] imemData;
    logic [18:0] ifIdInstruction;
    logic [11:0] ifIdPcPlus1;
    logic        ifIdValid;

    logic [18:0] mem [4096];

    typedef struct packed {
        logic [11:0] addr;
        logic [18:0] instr;
        logic [11:0] ppl;
        logic        valid;
    } expect_t;

    expect_t sbQueue[$];
    int checks = 0;
    int errors = 0;

    int          mPc;
    int          mPpl;
    logic [18:0] mInstr;
    logic        mValid;

    assign imemData = mem[imemAddr];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .pc_writebar       (pcWritebar),
        .IF_ID_loadbar     (ifIdLoadbar),
        .IF_ID_flush       (ifIdFlush),
        .do_branch         (doBranch),
        .imem_addr         (imemAddr),
        .imem_data         (imemData),
        .IF_ID_instruction (ifIdInstruction),
        .IF_ID_pc_plus1    (ifIdPcPlus1),
        .IF_ID_valid       (ifIdValid)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Redirect target from the architectural rules: absolute jump or signed offset mod 4096.
    function automatic int redirectTarget();
        int off;
        if (mInstr[18:16] == 3'b111) begin
            return int'(mInstr[11:0]);
        end
        off = mInstr[7] ? int'(mInstr[7:0]) - 256 : int'(mInstr[7:0]);
        return (((mPpl + off) % 4096) + 4096) % 4096;
    endfunction

    task automatic modelReset();
        mPc = 0;
        mPpl = 0;
        mInstr = '0;
        mValid = 1'b0;
    endtask

    // Drive one cycle of inputs at a negedge, predict the next edge, then wait a cycle.
    task automatic applyStimulus(input logic pwb, input logic lb, input logic fl, input logic br);
        expect_t e;
        int oldPc;
        pcWritebar = pwb;
        ifIdLoadbar = lb;
        ifIdFlush = fl;
        doBranch = br;
        oldPc = mPc;
        if (fl) begin
            mPc = redirectTarget();
            mInstr = '0;
            mPpl = 0;
            mValid = 1'b0;
        end else begin
            if (!lb) begin
                mInstr = mem[oldPc];
                mPpl = (oldPc + 1) % 4096;
                mValid = 1'b1;
            end
            if (!pwb) begin
                mPc = (oldPc + 1) % 4096;
            end
        end
        e.addr = 12'(mPc);
        e.instr = mInstr;
        e.ppl = 12'(mPpl);
        e.valid = mValid;
        sbQueue.push_back(e);
        @(negedge clk);
    endtask

    task automatic runSteps(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Async reset applied between edges; its effect is checked before any clock edge.
    task automatic doReset();
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_imem_addr", 32'(imemAddr), 32'h0);
        checkOutput("reset_instr", 32'(ifIdInstruction), 32'h0);
        checkOutput("reset_pc_plus1", 32'(ifIdPcPlus1), 32'h0);
        checkOutput("reset_valid", 32'(ifIdValid), 32'h0);
        sbQueue.delete();
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // Monitor: every edge outside reset must match the oldest prediction.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput("sb_imem_addr", 32'(imemAddr), 32'(e.addr));
                checkOutput("sb_instr", 32'(ifIdInstruction), 32'(e.instr));
                checkOutput("sb_pc_plus1", 32'(ifIdPcPlus1), 32'(e.ppl));
                checkOutput("sb_valid", 32'(ifIdValid), 32'(e.valid));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 19'($urandom);
        end
        mem[12'h00F] = {3'b101, 8'h00, 8'hFC};
        mem[12'h00C] = {3'b111, 4'h0, 12'h123};
        mem[12'h030] = {3'b111, 4'h5, 12'h040};
        modelReset();

        #1 reset = 1'b1;
        #1;
        checkOutput("init_imem_addr", 32'(imemAddr), 32'h0);
        checkOutput("init_valid", 32'(ifIdValid), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of sequential fetch, then fetch 0,1,2.
        runSteps(5);
        checkOutput("pre_reset_pc", 32'(imemAddr), 32'h005);
        doReset();
        runSteps(3);
        checkOutput("after_reset_pc_plus1", 32'(ifIdPcPlus1), 32'h003);
        checkOutput("after_reset_instr", 32'(ifIdInstruction), 32'(mem[2]));

        // Combined stall at 0x020.
        doReset();
        runSteps(32);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_imem_addr", 32'(imemAddr), 32'h020);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stall_release_addr", 32'(imemAddr), 32'h021);
        checkOutput("stall_release_instr", 32'(ifIdInstruction), 32'(mem[12'h020]));
        checkOutput("stall_release_ppl", 32'(ifIdPcPlus1), 32'h021);
        runSteps(1);
        checkOutput("stall_no_dup_instr", 32'(ifIdInstruction), 32'(mem[12'h021]));

        // Jump held in IF/ID redirects to 0x040.
        doReset();
        runSteps(49);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("jump_pc", 32'(imemAddr), 32'h040);
        checkOutput("jump_bubble_instr", 32'(ifIdInstruction), 32'h0);
        checkOutput("jump_bubble_valid", 32'(ifIdValid), 32'h0);
        runSteps(1);
        checkOutput("jump_fetch_instr", 32'(ifIdInstruction), 32'(mem[12'h040]));
        checkOutput("jump_fetch_ppl", 32'(ifIdPcPlus1), 32'h041);

        // Taken branch with offset -4 from pc_plus1 0x010, then flush that beats both holds.
        doReset();
        runSteps(16);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("branch_pc", 32'(imemAddr), 32'h00C);
        checkOutput("branch_bubble_valid", 32'(ifIdValid), 32'h0);
        runSteps(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_wins_pc", 32'(imemAddr), 32'h123);
        checkOutput("flush_wins_instr", 32'(ifIdInstruction), 32'h0);
        checkOutput("flush_wins_valid", 32'(ifIdValid), 32'h0);

        // PC wrap from 0xFFF to 0x000.
        doReset();
        runSteps(4095);
        checkOutput("wrap_pre_pc", 32'(imemAddr), 32'hFFF);
        runSteps(1);
        checkOutput("wrap_pc", 32'(imemAddr), 32'h000);
        checkOutput("wrap_ppl", 32'(ifIdPcPlus1), 32'h000);

        // Randomized mix of stalls, holds and flushes, with a reset mid-stall.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                pcWritebar = 1'b1;
                ifIdLoadbar = 1'b1;
                doReset();
            end
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 9) == 0, 1'($urandom));
        end

        @(negedge clk);
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
